ecc_receiver: RTL and testbench
===============================

# ecc_receiver

Receive-side stage of the error-correction lab datapath: it consumes the 16-bit Hamming(15,11)+overall-parity codewords that the transmitter stage leaves in data memory. For each codeword it computes the syndrome, corrects any single-bit error and flags double errors. It then writes the 11 recovered data bits plus a 2-bit status back to memory and raises `done` when all words are processed.

## Interface
Parameters:
- `W`, 8, memory data width
- `byte_count`, 256, memory depth; address width is $clog2(byte_count)
- `NUM_WORDS`, 15, codewords per run
- `SRC_BASE`, 30, byte address of codeword 0 (low byte at even offset, high byte at odd offset)
- `DST_BASE`, 60, byte address of decoded word 0

Ports:
- `clk`  in  1  sole clock, rising edge
- `init`  in  1  asynchronous, active-high reset; the run starts automatically on deassertion
- `raddr`  out  $clog2(byte_count)  memory read address
- `data_out`  in  W  memory read data, combinational from `raddr` in the same cycle
- `write_en`  out  1  memory store enable
- `waddr`  out  $clog2(byte_count)  memory write address
- `data_in`  out  W  memory write data
- `err1_cnt`  out  4  count of corrected single-error words this run
- `err2_cnt`  out  4  count of uncorrectable double-error words this run
- `done`  out  1  run complete, held high until `init`

## Operation
- Codeword bit k, for k = 1..15, is Hamming position k. Parity bits sit at cw[1], cw[2], cw[4] and cw[8]; cw[0] is overall parity p0.
- Data mapping: {b11..b5} = cw[15:9], {b4,b3,b2} = cw[7:5], b1 = cw[3].
- Syndrome s[3:0] = XOR of the indices of every set bit in cw[15:1]. P = ^cw[15:0].
- Decode rules:
  - s=0, P=0: clean, flag 2'b00.
  - P=1: single error at position s (s=0 means p0 itself is flipped). Flip bit s when s≠0, flag 2'b01, increment `err1_cnt`.
  - s≠0, P=0: double error, flag 2'b10, data taken uncorrected, increment `err2_cnt`.
- Outputs per word i:
  - mem[DST_BASE+2i] = {b8..b1}
  - mem[DST_BASE+2i+1] = {flag[1:0], 3'b000, b11, b10, b9}
- Per-word FSM: RD_LO → RD_HI → DECODE → WR_LO → WR_HI.
  - RD_LO: raddr = SRC_BASE+2i; capture into cw[7:0].
  - RD_HI: raddr = SRC_BASE+2i+1; capture into cw[15:8].
  - DECODE: register corrected data, flag and counter updates.
  - WR_LO: write_en = 1, waddr = DST_BASE+2i, data_in = low byte.
  - WR_HI: write_en = 1, waddr = DST_BASE+2i+1, data_in = high byte.
- After WR_HI: if i = NUM_WORDS-1, go to DONE; else increment i and go to RD_LO.
- DONE is sticky. In DONE: write_en = 0 and `done` = 1. Only `init` leaves DONE.
- Counters are 4-bit and saturate at 15; they never wrap.

## Timing
- Reset values (asynchronous, while `init` = 1): state RD_LO, i = 0, cw = 0, err1_cnt = 0, err2_cnt = 0, done = 0, write_en = 0, raddr = SRC_BASE, waddr = 0, data_in = 0.
- Cycle numbering: cycle 0 is the first clock period after `init` falls. Word i occupies cycles 5i..5i+4.
- Memory reads are combinational. The captured byte is the `data_out` value present at the rising edge that ends the RD cycle.
- Writes commit at the rising edge ending the WR cycle.
- Default NUM_WORDS: the last write is in cycle 74. `done` is registered high from cycle 75 onward; total latency is 75 cycles.
- Counter increments are visible from the cycle after DECODE.
- `init` asserted mid-run: all state clears immediately, with no completion of a pending write. Bytes already written stay in memory. The run restarts at word 0 after release.
- `init` held high: no writes occur, and `done` stays 0.

## Structure
- Package `ecc_pkg` holds:
  - the state enum (RD_LO, RD_HI, DECODE, WR_LO, WR_HI, DONE)
  - flag constants (FLAG_OK = 2'b00, FLAG_SEC = 2'b01, FLAG_DED = 2'b10)
  - data-bit position constants shared with the transmitter stage
- Sub-module `hamming_dec16` is purely combinational. Input: cw[15:0]. Outputs: data[10:0], flag[1:0], syndrome[3:0].
- The FSM, address generation, capture registers and counters live in `ecc_receiver`.

## Test plan
- Clean words: mem[30..31] = 0x00,0x00 and mem[32..33] = 0xFF,0xFF → mem[60..61] = 0x00,0x00; mem[62..63] = 0xFF,0x07; err counts 0/0.
- Single data error: codeword 0x0200 (bit 9 flipped from 0x0000) → mem[60..61] = 0x00,0x40; err1_cnt = 1.
- p0-only error: codeword 0xFFFE → mem = 0xFF,0x47; err1_cnt = 1, with no data bit changed.
- Double error: codeword 0x0028 → mem = 0x03,0x80; err2_cnt = 1; err1_cnt = 0.
- Full run of 15 mixed words → `done` first high exactly in cycle 75; write_en pulses exactly 30 times at addresses 60..89; `done` stays high for 20 more cycles.
- Assert `init` in cycle 37, then release → counters and `done` cleared immediately; after release, words 0..14 are fully rewritten and `done` rises 75 cycles later.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC receive stage: FSM states, status flags and
// the Hamming(15,11) data-bit positions also used by the transmitter stage.
package ecc_pkg;

    typedef enum logic [2:0] {
        RD_LO  = 3'd0,
        RD_HI  = 3'd1,
        DECODE = 3'd2,
        WR_LO  = 3'd3,
        WR_HI  = 3'd4,
        DONE   = 3'd5
    } state_e;

    localparam logic [1:0] FLAG_OK  = 2'b00;
    localparam logic [1:0] FLAG_SEC = 2'b01;
    localparam logic [1:0] FLAG_DED = 2'b10;

    // Codeword position of data bit b(j+1); element 0 is b1.
    localparam logic [10:0][3:0] DATA_POS = {
        4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9,
        4'd7, 4'd6, 4'd5, 4'd3
    };

endpackage

// File: rtl/hamming_dec16.sv
// Combinational Hamming(15,11) + overall-parity decoder: single-error
// correction, double-error detection and data extraction.
module hamming_dec16
    import ecc_pkg::*;
(
    input  logic [15:0] cw,
    output logic [10:0] data,
    output logic [1:0]  flag,
    output logic [3:0]  syndrome
);

    logic [15:0] fixed;
    logic        par;

    always_comb begin
        syndrome = '0;
        for (int k = 1; k < 16; k++) begin
            if (cw[k]) syndrome = syndrome ^ 4'(k);
        end
        par = ^cw;

        // Odd overall parity means one flip; syndrome 0 then points at p0 itself.
        fixed = cw;
        if (par && (syndrome != 4'd0)) fixed[syndrome] = ~cw[syndrome];

        if (par)                    flag = FLAG_SEC;
        else if (syndrome != 4'd0)  flag = FLAG_DED;
        else                        flag = FLAG_OK;

        data = '0;
        for (int j = 0; j < 11; j++) begin
            data[j] = fixed[DATA_POS[j]];
        end
    end

endmodule

// File: rtl/ecc_receiver.sv
// Receive-side ECC stage: reads codewords from memory, decodes them and writes
// back 11 data bits plus a status flag per word, counting corrected/failed words.
module ecc_receiver
    import ecc_pkg::*;
#(
    parameter int W          = 8,
    parameter int byte_count = 256,
    parameter int NUM_WORDS  = 15,
    parameter int SRC_BASE   = 30,
    parameter int DST_BASE   = 60
) (
    input  logic                          clk,
    input  logic                          init,
    output logic [$clog2(byte_count)-1:0] raddr,
    input  logic [W-1:0]                  data_out,
    output logic                          write_en,
    output logic [$clog2(byte_count)-1:0] waddr,
    output logic [W-1:0]                  data_in,
    output logic [3:0]                    err1_cnt,
    output logic [3:0]                    err2_cnt,
    output logic                          done
);

    localparam int AW = $clog2(byte_count);
    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    state_e         state_q, state_d;
    logic [IW-1:0]  idx_q;
    logic [15:0]    cw_q;
    logic [10:0]    data_q;
    logic [1:0]     flag_q;
    logic [3:0]     err1_q, err2_q;
    logic           done_q;

    logic [10:0]    dec_data;
    logic [1:0]     dec_flag;
    logic [3:0]     dec_syn;
    logic           is_sec, is_ded, last_word;
    logic [AW-1:0]  src_word, dst_word;

    hamming_dec16 u_dec (
        .cw       (cw_q),
        .data     (dec_data),
        .flag     (dec_flag),
        .syndrome (dec_syn)
    );

    assign is_sec    = (dec_flag == FLAG_SEC);
    assign is_ded    = (dec_syn != 4'd0) && !is_sec;
    assign last_word = (idx_q == IW'(NUM_WORDS - 1));
    assign src_word  = AW'(SRC_BASE) + AW'({idx_q, 1'b0});
    assign dst_word  = AW'(DST_BASE) + AW'({idx_q, 1'b0});

    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_LO:   state_d = RD_HI;
            RD_HI:   state_d = DECODE;
            DECODE:  state_d = WR_LO;
            WR_LO:   state_d = WR_HI;
            WR_HI:   state_d = last_word ? DONE : RD_LO;
            DONE:    state_d = DONE;
            default: state_d = RD_LO;
        endcase
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q <= RD_LO;
            idx_q   <= '0;
            cw_q    <= '0;
            data_q  <= '0;
            flag_q  <= FLAG_OK;
            err1_q  <= '0;
            err2_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                RD_LO:  cw_q[7:0]  <= data_out;
                RD_HI:  cw_q[15:8] <= data_out;
                DECODE: begin
                    data_q <= dec_data;
                    flag_q <= dec_flag;
                    // Saturating counters: a long run must never wrap back to a clean-looking value.
                    if (is_sec && (err1_q != 4'hF)) err1_q <= err1_q + 4'd1;
                    if (is_ded && (err2_q != 4'hF)) err2_q <= err2_q + 4'd1;
                end
                WR_HI: begin
                    if (last_word) done_q <= 1'b1;
                    else           idx_q  <= idx_q + IW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        raddr    = (state_q == RD_HI) ? src_word + AW'(1) : src_word;
        write_en = 1'b0;
        waddr    = '0;
        data_in  = '0;
        if (state_q == WR_LO) begin
            write_en = 1'b1;
            waddr    = dst_word;
            data_in  = data_q[7:0];
        end else if (state_q == WR_HI) begin
            write_en = 1'b1;
            waddr    = dst_word + AW'(1);
            data_in  = {flag_q, 3'b000, data_q[10:8]};
        end
    end

    assign err1_cnt = err1_q;
    assign err2_cnt = err2_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ecc_receiver.sv
// Directed bench for ecc_receiver: a byte memory model, two full runs and a
// mid-run re-initialisation, checked against hand-computed expectations.
module tb_ecc_receiver;

    logic       clk = 1'b0;
    logic       init;
    logic [7:0] raddr, waddr, data_out, data_in;
    logic       write_en, done;
    logic [3:0] err1_cnt, err2_cnt;

    logic [7:0] mem [0:255];
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr = '0;
    logic [7:0] pl_data = '0;

    int errors = 0;
    int checks = 0;
    int cyc;
    int wr_cnt, addr_bad, first_done;

    logic [15:0] w1    [15];
    logic [7:0]  e1_lo [15];
    logic [7:0]  e1_hi [15];

    ecc_receiver dut (
        .clk      (clk),
        .init     (init),
        .raddr    (raddr),
        .data_out (data_out),
        .write_en (write_en),
        .waddr    (waddr),
        .data_in  (data_in),
        .err1_cnt (err1_cnt),
        .err2_cnt (err2_cnt),
        .done     (done)
    );

    always #5 clk = ~clk;

    assign data_out = mem[raddr];

    always @(posedge clk) begin
        if (pl_en)         mem[pl_addr] <= pl_data;
        else if (write_en) mem[waddr]   <= data_in;
    end

    always @(posedge clk or posedge init) begin
        if (init) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Write-order and done-latency monitor, cleared whenever init is high.
    always @(negedge clk) begin
        if (init) begin
            wr_cnt     = 0;
            addr_bad   = 0;
            first_done = -1;
        end else begin
            if (write_en) begin
                if (waddr !== 8'(60 + wr_cnt)) addr_bad++;
                wr_cnt++;
            end
            if (done && first_done < 0) first_done = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = 8'(a);
        pl_data = d;
        @(posedge clk);
        #1;
        pl_en   = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        for (int k = 0; k < 300 && cyc < n; k++) tick();
        chk("cycle_reach", cyc, n);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 200 && !done; k++) tick();
        chk("done_seen", {31'd0, done}, 1);
    endtask

    task automatic release_init();
        @(posedge clk);
        #1;
        init = 1'b0;
    endtask

    initial begin
        w1 = '{16'h0000, 16'hFFFF, 16'h0200, 16'hFFFE, 16'h0028, 16'h0001, 16'h0003,
               16'h8001, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        e1_lo = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h03, 8'h00, 8'h00,
                  8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        e1_hi = '{8'h00, 8'h07, 8'h40, 8'h47, 8'h80, 8'h40, 8'h80,
                  8'h84, 8'h47, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        init = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_raddr", raddr, 30);
        chk("rst_write_en", write_en, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_done", done, 0);
        chk("rst_err1", err1_cnt, 0);
        chk("rst_err2", err2_cnt, 0);

        // Run 1: mixed clean / SEC / DED words.
        for (int i = 0; i < 15; i++) begin
            load(30 + 2*i, w1[i][7:0]);
            load(31 + 2*i, w1[i][15:8]);
        end
        for (int a = 60; a < 90; a++) load(a, 8'hEE);
        chk("held_no_write", write_en, 0);
        chk("held_done", done, 0);
        release_init();

        wait_cyc(12);
        chk("clean_err1", err1_cnt, 0);
        chk("clean_err2", err2_cnt, 0);
        wait_cyc(13);
        chk("sec_data_err1", err1_cnt, 1);
        wait_cyc(17);
        chk("pre_p0_err1", err1_cnt, 1);
        wait_cyc(18);
        chk("p0_err1", err1_cnt, 2);
        wait_cyc(22);
        chk("pre_ded_err2", err2_cnt, 0);
        wait_cyc(23);
        chk("ded_err2", err2_cnt, 1);
        chk("ded_err1", err1_cnt, 2);

        wait_done();
        chk("r1_done_cycle", first_done, 75);
        chk("r1_writes", wr_cnt, 30);
        chk("r1_addr_order", addr_bad, 0);
        chk("r1_err1", err1_cnt, 4);
        chk("r1_err2", err2_cnt, 3);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("r1_done_sticky", done, 1);
            chk("r1_idle_no_write", write_en, 0);
        end
        chk("r1_writes_after", wr_cnt, 30);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("r1_lo%0d", i), mem[60 + 2*i], e1_lo[i]);
            chk($sformatf("r1_hi%0d", i), mem[61 + 2*i], e1_hi[i]);
        end

        // Run 2: every word has only p0 flipped; init pulsed mid-run.
        init = 1'b1;
        #1;
        chk("init_clr_done", done, 0);
        chk("init_clr_err1", err1_cnt, 0);
        for (int i = 0; i < 15; i++) begin
            load(30 + 2*i, 8'h01);
            load(31 + 2*i, 8'h00);
        end
        for (int a = 60; a < 90; a++) load(a, 8'hEE);
        release_init();

        wait_cyc(37);
        chk("mid_err1", err1_cnt, 7);
        init = 1'b1;
        #1;
        chk("mid_clr_err1", err1_cnt, 0);
        chk("mid_clr_err2", err2_cnt, 0);
        chk("mid_clr_done", done, 0);
        chk("mid_clr_we", write_en, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_no_write", write_en, 0);
            chk("hold_no_done", done, 0);
        end
        chk("kept_byte73", mem[73], 8'h40);
        chk("no_pending_74", mem[74], 8'hEE);
        release_init();

        wait_done();
        chk("r2_done_cycle", first_done, 75);
        chk("r2_writes", wr_cnt, 30);
        chk("r2_addr_order", addr_bad, 0);
        chk("r2_err1", err1_cnt, 15);
        chk("r2_err2", err2_cnt, 0);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("r2_lo%0d", i), mem[60 + 2*i], 8'h00);
            chk($sformatf("r2_hi%0d", i), mem[61 + 2*i], 8'h40);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
